// File: rtl/add_serial_pkg.sv
// Shared types and constants for the add_serial scheduler.
package add_serial_pkg;

    localparam int unsigned ADD_W              = 8;
    localparam int unsigned RESULT_LAT_DEFAULT = 11;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StLoad    = 2'd1,
        StWait    = 2'd2,
        StCapture = 2'd3
    } sched_state_e;

endpackage

// File: rtl/add_serial_sched_if.sv
// Client and adder-side signal bundle of the add_serial scheduler.
interface add_serial_sched_if
    import add_serial_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = 2
) ();
    logic [NREQ-1:0]       req;
    logic [NREQ*ADD_W-1:0] a_in;
    logic [NREQ*ADD_W-1:0] b_in;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       rsp_valid;
    logic [ADD_W-1:0]      rsp_sum;
    logic [IDW-1:0]        rsp_id;
    logic                  busy;
    logic                  add_en;
    logic [ADD_W-1:0]      add_a;
    logic [ADD_W-1:0]      add_b;
    logic [ADD_W-1:0]      add_out;

    // master: clients plus the adder instance; slave: the scheduler
    modport master (
        output req, a_in, b_in, add_out,
        input  gnt, rsp_valid, rsp_sum, rsp_id, busy, add_en, add_a, add_b
    );

    modport slave (
        input  req, a_in, b_in, add_out,
        output gnt, rsp_valid, rsp_sum, rsp_id, busy, add_en, add_a, add_b
    );

endinterface

// File: rtl/add_serial_sched_rr_pick.sv
// Combinational round-robin picker: first set request at or above the pointer, wrapping.
module rr_pick #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = 2
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IDW-1:0]  i_ptr,
    output logic            o_found,
    output logic [IDW-1:0]  o_idx
);

    int unsigned w_pos;

    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        w_pos   = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            w_pos = (int'(i_ptr) + k) % NREQ;
            if (!o_found && i_req[w_pos]) begin
                o_found = 1'b1;
                o_idx   = IDW'(w_pos);
            end
        end
    end

endmodule

// File: rtl/add_serial_sched.sv
// Round-robin scheduler sharing one bit-serial add_serial adder among NREQ clients.
module add_serial_sched
    import add_serial_pkg::*;
#(
    parameter int unsigned NREQ       = 4,
    parameter int unsigned IDW        = 2,
    parameter int unsigned RESULT_LAT = RESULT_LAT_DEFAULT
) (
    input logic               clk,
    input logic               rst_n,
    add_serial_sched_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(RESULT_LAT);

    sched_state_e     r_state;
    sched_state_e     w_state_d;
    logic [IDW-1:0]   r_cur_id;
    logic [IDW-1:0]   r_rr_ptr;
    logic [CNT_W-1:0] r_wcnt;
    logic [ADD_W-1:0] r_add_a;
    logic [ADD_W-1:0] r_add_b;
    logic [ADD_W-1:0] r_rsp_sum;
    logic [IDW-1:0]   r_rsp_id;
    logic             w_found;
    logic [IDW-1:0]   w_idx;

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr_pick (
        .i_req   (bus.req),
        .i_ptr   (r_rr_ptr),
        .o_found (w_found),
        .o_idx   (w_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle:    if (w_found) w_state_d = StLoad;
            StLoad:    w_state_d = StWait;
            StWait:    if (r_wcnt == CNT_W'(RESULT_LAT - 1)) w_state_d = StCapture;
            StCapture: w_state_d = StIdle;
            default:   w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cur_id  <= '0;
            r_rr_ptr  <= '0;
            r_wcnt    <= '0;
            r_add_a   <= '0;
            r_add_b   <= '0;
            r_rsp_sum <= '0;
            r_rsp_id  <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    // Operands are frozen here; the adder rereads them while running.
                    if (w_found) begin
                        r_cur_id <= w_idx;
                        r_add_a  <= bus.a_in[ADD_W*w_idx +: ADD_W];
                        r_add_b  <= bus.b_in[ADD_W*w_idx +: ADD_W];
                    end
                end
                StLoad: r_wcnt <= CNT_W'(1);
                StWait: r_wcnt <= r_wcnt + 1'b1;
                StCapture: begin
                    r_rsp_sum <= bus.add_out;
                    r_rsp_id  <= r_cur_id;
                    r_rr_ptr  <= (r_cur_id == IDW'(NREQ - 1)) ? '0 : r_cur_id + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // The response strobe carries the live sum so owner, id and data line up in one cycle.
    always_comb begin
        bus.gnt       = '0;
        bus.rsp_valid = '0;
        bus.busy      = 1'b0;
        bus.add_en    = 1'b0;
        bus.rsp_sum   = r_rsp_sum;
        bus.rsp_id    = r_rsp_id;
        if (r_state != StIdle) begin
            bus.gnt[r_cur_id] = 1'b1;
            bus.busy          = 1'b1;
        end
        if (r_state == StLoad || r_state == StCapture) begin
            bus.add_en = 1'b1;
        end
        if (r_state == StCapture) begin
            bus.rsp_valid[r_cur_id] = 1'b1;
            bus.rsp_sum             = bus.add_out;
            bus.rsp_id              = r_cur_id;
        end
    end

    assign bus.add_a = r_add_a;
    assign bus.add_b = r_add_b;

endmodule

// File: tb/tb_add_serial_sched.sv
// Bench for add_serial_sched: behavioural adder, timeline reference model, directed and random stimulus.
module tb_add_serial_sched;
    import add_serial_pkg::*;

    localparam int unsigned NREQ = 4;
    localparam int unsigned IDW  = 2;
    localparam int          LAT  = RESULT_LAT_DEFAULT;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    add_serial_sched_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

    add_serial_sched #(
        .NREQ       (NREQ),
        .IDW        (IDW),
        .RESULT_LAT (LAT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Client-side drive
    logic [NREQ-1:0] t_req;
    logic [7:0]      t_a [NREQ];
    logic [7:0]      t_b [NREQ];
    logic            auto_drop;

    always_comb begin
        bus.req  = t_req;
        bus.a_in = '0;
        bus.b_in = '0;
        for (int i = 0; i < NREQ; i++) begin
            bus.a_in[8*i +: 8] = t_a[i];
            bus.b_in[8*i +: 8] = t_b[i];
        end
    end

    // Behavioural adder: sum appears LAT cycles after the start pulse, garbage otherwise
    // or if the operands move while it is running.
    int         ad_cnt;
    logic [7:0] ad_a0, ad_b0;
    logic       ad_bad;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ad_cnt <= 0;
            ad_a0  <= '0;
            ad_b0  <= '0;
            ad_bad <= 1'b0;
        end else if (ad_cnt == 0) begin
            if (bus.add_en) begin
                ad_cnt <= 1;
                ad_a0  <= bus.add_a;
                ad_b0  <= bus.add_b;
                ad_bad <= 1'b0;
            end
        end else if (ad_cnt == LAT) begin
            if (bus.add_en) ad_cnt <= 0;
        end else begin
            ad_cnt <= ad_cnt + 1;
            if (bus.add_a != ad_a0 || bus.add_b != ad_b0) ad_bad <= 1'b1;
        end
    end

    always_comb begin
        bus.add_out = 8'h5A ^ 8'(ad_cnt);
        if (ad_cnt == LAT && !ad_bad) bus.add_out = ad_a0 + ad_b0;
    end

    // Reference model: one transaction timeline (load cycle, capture cycle, owner, operands)
    int         n;
    int         m_load, m_cap, m_owner, m_ptr, m_last_id;
    logic [7:0] m_a, m_b, m_opa, m_opb, m_last_sum;

    int         ev_cyc [$];
    logic [3:0] ev_vec [$];
    logic [7:0] ev_sum [$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", tag, n, got, exp);
    endtask

    function automatic int pick(input logic [NREQ-1:0] r, input int p);
        for (int k = 0; k < NREQ; k++) begin
            if (r[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return 0;
    endfunction

    task automatic model_reset();
        m_load     = -1;
        m_cap      = -1;
        m_owner    = 0;
        m_ptr      = 0;
        m_last_id  = 0;
        m_a        = '0;
        m_b        = '0;
        m_opa      = '0;
        m_opb      = '0;
        m_last_sum = '0;
    endtask

    task automatic cycle_begin();
        logic active;
        @(negedge clk);
        n++;
        if (n == m_load) begin
            m_opa = m_a;
            m_opb = m_b;
        end
        if (n == m_cap) begin
            m_last_sum = m_a + m_b;
            m_last_id  = m_owner;
            m_ptr      = (m_owner + 1) % NREQ;
        end
        active = (n >= m_load) && (n <= m_cap);
        check("gnt",       32'(bus.gnt),       active ? (32'd1 << m_owner) : 32'd0);
        check("busy",      32'(bus.busy),      32'(active));
        check("add_en",    32'(bus.add_en),    32'((n == m_load) || (n == m_cap)));
        check("rsp_valid", 32'(bus.rsp_valid), (n == m_cap) ? (32'd1 << m_owner) : 32'd0);
        check("rsp_sum",   32'(bus.rsp_sum),   32'(m_last_sum));
        check("rsp_id",    32'(bus.rsp_id),    32'(m_last_id));
        check("add_a",     32'(bus.add_a),     32'(m_opa));
        check("add_b",     32'(bus.add_b),     32'(m_opb));
        if (bus.rsp_valid != '0) begin
            ev_cyc.push_back(n);
            ev_vec.push_back(bus.rsp_valid);
            ev_sum.push_back(bus.rsp_sum);
        end
    endtask

    task automatic cycle_end();
        int p;
        if (rst_n && n > m_cap && t_req != '0) begin
            p       = pick(t_req, m_ptr);
            m_owner = p;
            m_a     = t_a[p];
            m_b     = t_b[p];
            m_load  = n + 1;
            m_cap   = n + 1 + LAT;
        end
    endtask

    task automatic tick();
        cycle_begin();
        if (auto_drop && n == m_cap) t_req[m_owner] = 1'b0;
        cycle_end();
    endtask

    task automatic do_reset();
        cycle_begin();
        rst_n = 1'b0;
        t_req = '0;
        #1;
        check("rst_gnt",       32'(bus.gnt),       0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 0);
        check("rst_busy",      32'(bus.busy),      0);
        check("rst_add_en",    32'(bus.add_en),    0);
        check("rst_rsp_sum",   32'(bus.rsp_sum),   0);
        check("rst_rsp_id",    32'(bus.rsp_id),    0);
        check("rst_add_a",     32'(bus.add_a),     0);
        check("rst_add_b",     32'(bus.add_b),     0);
        model_reset();
        cycle_end();
        tick();
        tick();
        cycle_begin();
        rst_n = 1'b1;
        cycle_end();
    endtask

    task automatic clear_log();
        ev_cyc.delete();
        ev_vec.delete();
        ev_sum.delete();
    endtask

    initial begin
        int r;
        n         = 0;
        auto_drop = 1'b1;
        t_req     = '0;
        for (int i = 0; i < NREQ; i++) begin
            t_a[i] = '0;
            t_b[i] = '0;
        end
        model_reset();
        do_reset();

        // Single request, latency and sum
        clear_log();
        cycle_begin();
        t_req[0] = 1'b1; t_a[0] = 8'h25; t_b[0] = 8'h13; r = n;
        cycle_end();
        repeat (20) tick();
        check("t1_count", ev_cyc.size(), 1);
        if (ev_cyc.size() >= 1) begin
            check("t1_latency", ev_cyc[0] - r, 12);
            check("t1_sum",     32'(ev_sum[0]), 32'h38);
            check("t1_vec",     32'(ev_vec[0]), 32'h1);
        end

        // All four from reset: order 0..3, period 13
        do_reset();
        clear_log();
        cycle_begin();
        t_req = 4'hF;
        for (int i = 0; i < NREQ; i++) begin
            t_a[i] = 8'(i);
            t_b[i] = 8'h10;
        end
        cycle_end();
        repeat (60) tick();
        check("t2_count", ev_cyc.size(), 4);
        for (int k = 0; k < 4 && k < ev_cyc.size(); k++) begin
            check("t2_vec", 32'(ev_vec[k]), 32'd1 << k);
            check("t2_sum", 32'(ev_sum[k]), 32'h10 + k);
            if (k > 0) check("t2_period", ev_cyc[k] - ev_cyc[k-1], 13);
        end

        // Wrap-around with clients 0 and 3 requesting continuously
        auto_drop = 1'b0;
        clear_log();
        cycle_begin();
        t_req = 4'b1001;
        t_a[0] = 8'h01; t_b[0] = 8'h02; t_a[3] = 8'h03; t_b[3] = 8'h04;
        cycle_end();
        repeat (56) tick();
        check("t3_count", ev_cyc.size(), 4);
        for (int k = 0; k < 4 && k < ev_cyc.size(); k++) begin
            check("t3_vec", 32'(ev_vec[k]), (k % 2 == 0) ? 32'h1 : 32'h8);
        end
        cycle_begin();
        t_req = '0;
        cycle_end();
        auto_drop = 1'b1;
        repeat (15) tick();

        // Overflow wraps mod 256
        clear_log();
        cycle_begin();
        t_req[1] = 1'b1; t_a[1] = 8'hFF; t_b[1] = 8'h02;
        cycle_end();
        repeat (16) tick();
        check("t4_count", ev_cyc.size(), 1);
        if (ev_sum.size() >= 1) check("t4_sum", 32'(ev_sum[0]), 32'h01);

        // Owner changes operands during WAIT
        clear_log();
        cycle_begin();
        t_req[2] = 1'b1; t_a[2] = 8'h40; t_b[2] = 8'h01;
        cycle_end();
        repeat (4) tick();
        cycle_begin();
        t_a[2] = 8'h77; t_b[2] = 8'h99;
        cycle_end();
        repeat (12) tick();
        check("t5_count", ev_cyc.size(), 1);
        if (ev_sum.size() >= 1) check("t5_sum", 32'(ev_sum[0]), 32'h41);

        // Reset in WAIT cycle 5, then a clean request
        clear_log();
        cycle_begin();
        t_req[2] = 1'b1; t_a[2] = 8'h0A; t_b[2] = 8'h0B;
        cycle_end();
        repeat (5) tick();
        do_reset();
        check("t6_aborted", ev_cyc.size(), 0);
        cycle_begin();
        t_req[1] = 1'b1; t_a[1] = 8'h11; t_b[1] = 8'h22; r = n;
        cycle_end();
        repeat (16) tick();
        check("t6_count", ev_cyc.size(), 1);
        if (ev_cyc.size() >= 1) begin
            check("t6_latency", ev_cyc[0] - r, 12);
            check("t6_sum",     32'(ev_sum[0]), 32'h33);
        end

        // Random traffic: raise, hold, re-request, abandon, wiggle operands
        for (int c = 0; c < 1500; c++) begin
            cycle_begin();
            for (int i = 0; i < NREQ; i++) begin
                if (t_req[i]) begin
                    if (n == m_cap && m_owner == i) begin
                        if ($urandom_range(3) != 0) t_req[i] = 1'b0;
                    end else if ($urandom_range(39) == 0) begin
                        t_req[i] = 1'b0;
                    end else if ($urandom_range(9) == 0) begin
                        t_a[i] = 8'($urandom);
                    end
                end else if ($urandom_range(4) == 0) begin
                    t_req[i] = 1'b1;
                    t_a[i]   = 8'($urandom);
                    t_b[i]   = 8'($urandom);
                end
            end
            cycle_end();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/add_serial_sched.md
# add_serial_sched

Round-robin scheduler that shares one `add_serial` bit-serial 8-bit adder among `NREQ` requesters. It sequences the adder's `en` protocol: start pulse, fixed-latency wait, result capture and release pulse. It returns each sum to its owner with a one-cycle response strobe. It sits between the client blocks and a single `add_serial` instance, which it drives directly.

## Interface
Parameters:
- `NREQ`, 4: number of requesters (2..8).
- `IDW`, 2: requester index width, equal to clog2(`NREQ`).
- `RESULT_LAT`, 11: number of cycles from the start pulse to the cycle in which the adder `out` holds the final sum.

Ports:
- `clk`  in  1  clock; all logic is rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  `NREQ`  request per client; held with operands stable until that client's `rsp_valid`.
- `a_in`  in  `NREQ`*8  operand A; client i occupies bits [8i+7:8i].
- `b_in`  in  `NREQ`*8  operand B; same packing as `a_in`.
- `gnt`  out  `NREQ`  one-hot; the current owner of the adder.
- `rsp_valid`  out  `NREQ`  one-cycle strobe to the owner when its sum is ready.
- `rsp_sum`  out  8  captured sum; holds its value until the next capture.
- `rsp_id`  out  `IDW`  index of the client that owns `rsp_sum`.
- `busy`  out  1  high from LOAD through CAPTURE.
- `add_en`  out  1  drives the adder `en`.
- `add_a`, `add_b`  out  8 each  drive the adder `a` and `b`.
- `add_out`  in  8  from the adder `out`.

## Operation
- FSM states: IDLE, LOAD, WAIT, CAPTURE. The encoding is 2 bits.
- IDLE:
  - With no `req` bit set, stay in IDLE.
  - Otherwise pick the first set `req` bit at or above `rr_ptr`, wrapping modulo `NREQ`.
  - Latch its index into `cur_id` and its operands into `add_a`/`add_b`, then go to LOAD.
- LOAD: `add_en`=1 for this cycle only; clear `wcnt` to 1; go to WAIT.
- WAIT:
  - `add_en`=0.
  - Increment `wcnt` each cycle.
  - When `wcnt`==`RESULT_LAT`-1, go to CAPTURE.
- CAPTURE:
  - `rsp_sum`<=`add_out`; `rsp_id`<=`cur_id`; `rsp_valid`[`cur_id`]=1 for one cycle.
  - `add_en`=1, which releases the adder from DONE to IDLE.
  - `rr_ptr`<=(`cur_id`+1) mod `NREQ`.
  - Go to IDLE.
- `gnt`=onehot(`cur_id`) in LOAD, WAIT and CAPTURE; 0 in IDLE.
- `add_a`/`add_b` are constant from LOAD through CAPTURE. The adder reloads operands in its delay0 state, so the values must not change mid-operation.
- Sum width: 8 bits; carry-out is discarded (mod 256). The scheduler passes `add_out` through unmodified.
- If a client drops `req` mid-operation, the operation still completes and `rsp_valid` still pulses. The client ignores it.
- A `req` bit that rises in any non-IDLE state is only considered at the next IDLE.
- `req` from the client just served, still high in the IDLE cycle after CAPTURE, is lowest priority because of `rr_ptr`.

## Timing
- Reset values: `gnt`=0, `rsp_valid`=0, `rsp_sum`=0, `rsp_id`=0, `busy`=0, `add_en`=0, `add_a`=0, `add_b`=0, `rr_ptr`=0, FSM=IDLE.
- Reset is asynchronous on assertion and applies mid-operation too. The adder is reset by the same system reset, so both restart in IDLE.
- If LOAD is at cycle t:
  - CAPTURE is at t+`RESULT_LAT` (default t+11).
  - IDLE is at t+`RESULT_LAT`+1.
  - The earliest next LOAD is t+`RESULT_LAT`+2.
  - Back-to-back period is `RESULT_LAT`+2 cycles (13).
- Latency from `req` rising while idle to `rsp_valid` is `RESULT_LAT`+1 cycles (12).
- `add_en` is never high for two consecutive cycles.

## Structure
- Shared package `add_serial_pkg`:
  - FSM state enum.
  - `RESULT_LAT_DEFAULT`=11.
  - `ADD_W`=8.
- One sub-module: `rr_pick`, a combinational round-robin priority picker. Inputs: `req` vector and `rr_ptr`. Outputs: `found` and `idx`.
- The adder is instantiated by the parent, not inside this block.

## Test plan
- Single request: client 0 with a=0x25, b=0x13. Expect `gnt`=0001 for 12 cycles, then `rsp_valid`[0] at +12 with `rsp_sum`=0x38 and `rsp_id`=0.
- All four requesting from reset, each with a=i, b=0x10. Expect grants in order 0,1,2,3, `rsp_sum`=0x10..0x13, and strobes 13 cycles apart.
- Wrap-around: clients 0 and 3 request continuously. Expect grant order 0,3,0,3 and `rr_ptr` to wrap 3→0.
- Overflow: a=0xFF, b=0x02. Expect `rsp_sum`=0x01, with no carry output.
- Operand change: drive `a_in` of the owner to a new value during WAIT. Expect the sum to use the originally latched operands.
- Reset mid-operation: assert `rst_n`=0 in WAIT cycle 5. Expect all outputs at reset values immediately. After release, a new request produces the correct sum with 12-cycle latency.
